knn_stream_ctrl: RTL and testbench
==================================

// Module: knn_stream_ctrl
// PURPOSE
//  Sequencer for the KNN accelerator core (knnTop_regwrap datapath). Accepts a valid/ready word stream
//  (reference vector, then cfg_num_points training vectors) and drives core start/wr_en/done/rd_en with
//  the required timing. Drains the core, then reads back the k nearest results onto a valid/ready stream.
//  Sits between the AXI/DMA front end and the core.
// PARAMETERS
//  DATA_WIDTH    32  width of stream words and core data
//  NUM_DIMS      5   dimensions per vector; must be >= 1 and match the core
//  MAX_K         16  largest legal cfg_k
//  CNT_WIDTH     16  width of cfg_num_points and the point counter
//  DRAIN_CYCLES  10  cycles core_done is held before the first core_rd_en; must be >= 1
// PORTS
//  clk             in   1           rising-edge clock
//  reset           in   1           asynchronous, active-low reset
//  cfg_k           in   32          neighbours to return; sampled on accepted cmd_start
//  cfg_num_points  in   CNT_WIDTH   training vectors per job; sampled on accepted cmd_start
//  cmd_start       in   1           one-cycle job request; ignored while busy
//  busy            out  1           high from cmd_start acceptance until the job returns to IDLE
//  err_cfg         out  1           one-cycle pulse when cmd_start is rejected for bad configuration
//  irq_done        out  1           one-cycle pulse on the cycle the job completes
//  s_data          in   DATA_WIDTH  input stream word
//  s_valid         in   1           input word valid
//  s_ready         out  1           controller accepts the word; beat = s_valid & s_ready
//  core_start      out  1           core start level
//  core_wr_en      out  1           core write enable
//  core_rd_en      out  1           core read-strobe
//  core_done       out  1           core end-of-data level
//  core_k          out  32          registered cfg_k
//  core_data_in    out  DATA_WIDTH  word to core
//  core_name_out   in   32          core result index
//  core_value_out  in   32          core result distance
//  m_name          out  32          result index
//  m_value         out  32          result distance
//  m_valid         out  1           result valid
//  m_last          out  1           marks the k-th result
//  m_ready         in   1           downstream accepts the result
// BEHAVIOUR
//  Reset (any cycle, including mid-job): return to IDLE; every output and counter goes to 0.
//  FSM states: IDLE, LOAD_REF, LOAD_PTS, DRAIN, RD_REQ, RD_WAIT, OUT.
//  IDLE: cmd_start is accepted only when 1<=cfg_k<=MAX_K, cfg_num_points>=1 and cfg_k<=cfg_num_points;
//    accept -> latch cfg_k/cfg_num_points, core_k<=cfg_k, go to LOAD_REF. Otherwise pulse err_cfg, stay in IDLE.
//  core_start=1 in every state except IDLE. s_ready=1 only in LOAD_REF and LOAD_PTS.
//  Each beat: core_data_in<=s_data and core_wr_en=1 on the next cycle (registered, latency 1).
//    Without a beat, core_wr_en=0 and core_data_in holds its value.
//  dim_cnt counts beats 0..NUM_DIMS-1 and wraps to 0. LOAD_REF->LOAD_PTS on the beat where dim_cnt==NUM_DIMS-1.
//  LOAD_PTS: pt_cnt increments when dim_cnt wraps; on the wrap that makes pt_cnt==cfg_num_points -> DRAIN
//    (s_ready falls the next cycle; no extra beat is accepted).
//  DRAIN: core_done=1 and stays 1 until IDLE; wait exactly DRAIN_CYCLES cycles, then -> RD_REQ.
//  RD_REQ: core_rd_en=1 for one cycle -> RD_WAIT. RD_WAIT: capture core_name_out/core_value_out into m_name/m_value,
//    set m_valid=1; m_last=1 if this is result #cfg_k -> OUT.
//  OUT: hold m_* stable while m_valid & !m_ready. On m_ready: m_valid<=0; if m_last -> IDLE with irq_done pulse,
//    else -> RD_REQ. Exactly cfg_k rd_en strobes per job; gap between results >= 2 cycles.
//  cmd_start asserted while busy is ignored (no error pulse). s_valid outside the load states is not accepted.
//  Counter widths: dim_cnt $clog2(NUM_DIMS) with a minimum of 1 bit; pt_cnt CNT_WIDTH; result counter 32 bits.
// TESTING
//  k=3, N=5, NUM_DIMS=5, 30 back-to-back beats, m_ready=1 -> 30 core_wr_en pulses, core_done after beat 30,
//    3 rd_en strobes, 3 results, m_last on the 3rd, irq_done once.
//  Same job with s_valid toggling 50% -> identical core_data_in sequence; s_ready=0 after last beat.
//  m_ready held 0 for 7 cycles on result 2 -> m_name/m_value stable; no extra rd_en until accepted.
//  cmd_start with k=0, k=17, N=0, or k=4/N=3 -> err_cfg pulse, busy stays 0, no core activity.
//  reset driven low during LOAD_PTS after 12 beats -> all outputs 0 next edge; a new job then runs cleanly.
//  cmd_start pulsed during DRAIN -> ignored; the job finishes with exactly cfg_k results.

Source files
------------

// File: rtl/knn_stream_ctrl.sv
// knn_stream_ctrl: job sequencer in front of the KNN core.
// Loads the reference vector and cfg_num_points training vectors from a
// valid/ready stream into the core, holds core_done for a fixed drain time,
// then reads back cfg_k results one at a time onto a valid/ready stream.
module knn_stream_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_DIMS     = 5,
  parameter int MAX_K        = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cfg_k,
  input  logic [CNT_WIDTH-1:0]  cfg_num_points,
  input  logic                  cmd_start,
  output logic                  busy,
  output logic                  err_cfg,
  output logic                  irq_done,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  core_start,
  output logic                  core_wr_en,
  output logic                  core_rd_en,
  output logic                  core_done,
  output logic [31:0]           core_k,
  output logic [DATA_WIDTH-1:0] core_data_in,
  input  logic [31:0]           core_name_out,
  input  logic [31:0]           core_value_out,
  output logic [31:0]           m_name,
  output logic [31:0]           m_value,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int DIM_W = (NUM_DIMS > 1) ? $clog2(NUM_DIMS) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_REF = 3'd1,
    LOAD_PTS = 3'd2,
    DRAIN    = 3'd3,
    RD_REQ   = 3'd4,
    RD_WAIT  = 3'd5,
    OUT      = 3'd6
  } state_t;

  state_t               state_r;
  logic [31:0]          k_r;
  logic [CNT_WIDTH-1:0] n_r;
  logic [DIM_W-1:0]     dim_cnt_r;
  logic [CNT_WIDTH-1:0] pt_cnt_r;
  logic [31:0]          res_cnt_r;
  logic [DRN_W-1:0]     drain_cnt_r;

  logic beat_s;
  logic dim_last_s;
  logic drain_last_s;
  logic pts_last_s;

  // A job needs at least one neighbour, no more than MAX_K, and enough points to rank.
  function automatic logic cfg_ok(input logic [31:0] k, input logic [CNT_WIDTH-1:0] n);
    cfg_ok = (k >= 32'd1) && (k <= 32'(MAX_K)) &&
             (n != {CNT_WIDTH{1'b0}}) && (k <= 32'(n));
  endfunction

  assign beat_s       = s_valid & s_ready;
  assign dim_last_s   = (dim_cnt_r == DIM_W'(NUM_DIMS - 1));
  assign drain_last_s = (drain_cnt_r == DRN_W'(DRAIN_CYCLES - 1));
  assign pts_last_s   = ((pt_cnt_r + CNT_WIDTH'(1)) == n_r);

  // Job sequencer: state, counters and every registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      k_r          <= 32'd0;
      n_r          <= {CNT_WIDTH{1'b0}};
      dim_cnt_r    <= {DIM_W{1'b0}};
      pt_cnt_r     <= {CNT_WIDTH{1'b0}};
      res_cnt_r    <= 32'd0;
      drain_cnt_r  <= {DRN_W{1'b0}};
      busy         <= 1'b0;
      err_cfg      <= 1'b0;
      irq_done     <= 1'b0;
      s_ready      <= 1'b0;
      core_start   <= 1'b0;
      core_wr_en   <= 1'b0;
      core_rd_en   <= 1'b0;
      core_done    <= 1'b0;
      core_k       <= 32'd0;
      core_data_in <= {DATA_WIDTH{1'b0}};
      m_name       <= 32'd0;
      m_value      <= 32'd0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
    end else begin
      err_cfg  <= 1'b0;
      irq_done <= 1'b0;
      // s_ready is only high in the load states, so a beat is always a load word.
      if (beat_s) begin
        core_wr_en   <= 1'b1;
        core_data_in <= s_data;
      end else begin
        core_wr_en   <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (cmd_start) begin
            if (cfg_ok(cfg_k, cfg_num_points)) begin
              k_r         <= cfg_k;
              n_r         <= cfg_num_points;
              core_k      <= cfg_k;
              dim_cnt_r   <= {DIM_W{1'b0}};
              pt_cnt_r    <= {CNT_WIDTH{1'b0}};
              res_cnt_r   <= 32'd0;
              drain_cnt_r <= {DRN_W{1'b0}};
              busy        <= 1'b1;
              core_start  <= 1'b1;
              s_ready     <= 1'b1;
              state_r     <= LOAD_REF;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end

        LOAD_REF: begin
          if (beat_s) begin
            if (dim_last_s) begin
              dim_cnt_r <= {DIM_W{1'b0}};
              state_r   <= LOAD_PTS;
            end else begin
              dim_cnt_r <= dim_cnt_r + DIM_W'(1);
            end
          end
        end

        LOAD_PTS: begin
          if (beat_s) begin
            if (dim_last_s) begin
              dim_cnt_r <= {DIM_W{1'b0}};
              pt_cnt_r  <= pt_cnt_r + CNT_WIDTH'(1);
              if (pts_last_s) begin
                s_ready     <= 1'b0;
                core_done   <= 1'b1;
                drain_cnt_r <= {DRN_W{1'b0}};
                state_r     <= DRAIN;
              end
            end else begin
              dim_cnt_r <= dim_cnt_r + DIM_W'(1);
            end
          end
        end

        // core_done has been high for DRAIN_CYCLES cycles when the first strobe appears.
        DRAIN: begin
          if (drain_last_s) begin
            core_rd_en <= 1'b1;
            state_r    <= RD_REQ;
          end else begin
            drain_cnt_r <= drain_cnt_r + DRN_W'(1);
          end
        end

        RD_REQ: begin
          core_rd_en <= 1'b0;
          state_r    <= RD_WAIT;
        end

        RD_WAIT: begin
          m_name    <= core_name_out;
          m_value   <= core_value_out;
          m_valid   <= 1'b1;
          m_last    <= ((res_cnt_r + 32'd1) == k_r);
          res_cnt_r <= res_cnt_r + 32'd1;
          state_r   <= OUT;
        end

        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              irq_done   <= 1'b1;
              busy       <= 1'b0;
              core_start <= 1'b0;
              core_done  <= 1'b0;
              state_r    <= IDLE;
            end else begin
              core_rd_en <= 1'b1;
              state_r    <= RD_REQ;
            end
          end
        end

        default: begin
          busy       <= 1'b0;
          core_start <= 1'b0;
          core_done  <= 1'b0;
          core_rd_en <= 1'b0;
          s_ready    <= 1'b0;
          m_valid    <= 1'b0;
          m_last     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_stream_ctrl.sv
// Directed bench for knn_stream_ctrl with a small behavioural core model.
module tb_knn_stream_ctrl;

  localparam logic [31:0] BASE = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_k;
  logic [15:0] cfg_num_points;
  logic        cmd_start;
  logic        busy, err_cfg, irq_done;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic        core_start, core_wr_en, core_rd_en, core_done;
  logic [31:0] core_k, core_data_in;
  logic [31:0] core_name_out = 32'd0;
  logic [31:0] core_value_out = 32'd0;
  logic [31:0] m_name, m_value;
  logic        m_valid, m_last, m_ready;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int          wr_cnt = 0, rd_cnt = 0, irq_cnt = 0, err_cnt = 0;
  int          drain_cyc = 0, last_drain = 0, wr_at_done = 0;
  bit          rd_seen = 1'b0, done_seen = 1'b0;
  logic [31:0] wr_q[$];
  logic [31:0] res_name[$];
  logic [31:0] res_value[$];
  logic        res_last[$];

  knn_stream_ctrl dut (
    .clk(clk), .reset(reset), .cfg_k(cfg_k), .cfg_num_points(cfg_num_points),
    .cmd_start(cmd_start), .busy(busy), .err_cfg(err_cfg), .irq_done(irq_done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .core_start(core_start), .core_wr_en(core_wr_en), .core_rd_en(core_rd_en),
    .core_done(core_done), .core_k(core_k), .core_data_in(core_data_in),
    .core_name_out(core_name_out), .core_value_out(core_value_out),
    .m_name(m_name), .m_value(m_value), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Core model and traffic monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (core_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      wr_q.push_back(core_data_in);
    end
    if (core_rd_en) begin
      rd_cnt         <= rd_cnt + 1;
      core_name_out  <= 32'h100 + 32'(rd_cnt) + 32'd1;
      core_value_out <= 32'h5000 + 32'(rd_cnt) + 32'd1;
    end
    if (irq_done) irq_cnt <= irq_cnt + 1;
    if (err_cfg) err_cnt <= err_cnt + 1;
    if (m_valid && m_ready) begin
      res_name.push_back(m_name);
      res_value.push_back(m_value);
      res_last.push_back(m_last);
    end
    if (!core_start) begin
      drain_cyc <= 0;
      rd_seen   <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      if (core_done && !rd_seen && !core_rd_en) drain_cyc <= drain_cyc + 1;
      if (core_rd_en && !rd_seen) begin
        rd_seen    <= 1'b1;
        last_drain <= drain_cyc;
      end
      if (core_done && !done_seen) begin
        done_seen  <= 1'b1;
        wr_at_done <= wr_cnt + (core_wr_en ? 1 : 0);
      end
    end
  end

  function automatic logic [137:0] outs();
    return {busy, err_cfg, irq_done, s_ready, core_start, core_wr_en, core_rd_en,
            core_done, m_valid, m_last, core_k, core_data_in, m_name, m_value};
  endfunction

  task automatic start_cmd(input logic [31:0] k, input logic [15:0] n);
    @(posedge clk); #1;
    cfg_k = k; cfg_num_points = n; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic send_beats(input int total, input bit toggle, input logic [31:0] base);
    bit ok = 1'b1;
    for (int i = 0; i < total && ok; i++) begin
      bit acc = 1'b0;
      int n = 0;
      s_data = base + 32'(i);
      s_valid = 1'b1;
      while (!acc && n < 50) begin
        @(negedge clk);
        if (s_ready) acc = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) ok = 1'b0;
      if (toggle) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL beats: s_ready stayed 0, wanted %0d beats accepted", total);
    end
  endtask

  task automatic wait_done(input int i0, input int budget);
    int n = 0;
    while (irq_cnt == i0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (irq_cnt == i0) begin
      errors++;
      $display("FAIL irq_timeout: no irq_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_k = 32'd0; cfg_num_points = 16'd0; cmd_start = 1'b0;
    s_data = 32'd0; s_valid = 1'b0; m_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== {138{1'b0}}) begin
      errors++; $display("FAIL reset_outs: got %h want 0", outs());
    end
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (outs() !== {138{1'b0}}) begin
      errors++; $display("FAIL idle_outs: got %h want 0", outs());
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt, r0 = rd_cnt, i0 = irq_cnt, q0 = res_name.size(), d0 = wr_q.size();
    m_ready = 1'b1;
    start_cmd(32'd3, 16'd5);
    checks++;
    if (busy !== 1'b1 || core_k !== 32'd3 || core_start !== 1'b1) begin
      errors++; $display("FAIL accept: busy=%b core_k=%0d start=%b want 1 3 1", busy, core_k, core_start);
    end
    send_beats(30, 1'b0, BASE);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_sready: got %b want 0", s_ready);
    end
    wait_done(i0, 300);
    checks++;
    if (wr_cnt - w0 !== 30 || wr_at_done !== w0 + 30) begin
      errors++; $display("FAIL b2b_wr: wr=%0d at_done=%0d want 30 %0d", wr_cnt - w0, wr_at_done, w0 + 30);
    end
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (d0 + i >= wr_q.size() || wr_q[d0 + i] !== BASE + 32'(i)) begin
        errors++; $display("FAIL b2b_data%0d: got %h want %h", i,
                           (d0 + i < wr_q.size()) ? wr_q[d0 + i] : 32'hX, BASE + 32'(i));
      end
    end
    checks++;
    if (last_drain !== 10 || rd_cnt - r0 !== 3 || irq_cnt - i0 !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done: drain=%0d rd=%0d irq=%0d busy=%b want 10 3 1 0",
                         last_drain, rd_cnt - r0, irq_cnt - i0, busy);
    end
    checks++;
    if (res_name.size() - q0 !== 3) begin
      errors++; $display("FAIL b2b_nres: got %0d want 3", res_name.size() - q0);
    end
    for (int j = 0; j < 3; j++) begin
      if (q0 + j < res_name.size()) begin
        checks++;
        if (res_name[q0 + j] !== 32'h100 + 32'(r0 + j + 1) || res_value[q0 + j] !== 32'h5000 + 32'(r0 + j + 1) ||
            res_last[q0 + j] !== ((j == 2) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL b2b_res%0d: name=%h value=%h last=%b want %h %h %b", j,
                             res_name[q0 + j], res_value[q0 + j], res_last[q0 + j],
                             32'h100 + 32'(r0 + j + 1), 32'h5000 + 32'(r0 + j + 1), (j == 2));
        end
      end
    end
  endtask

  task automatic test_toggle();
    int w0 = wr_cnt, r0 = rd_cnt, i0 = irq_cnt, q0 = res_name.size(), d0 = wr_q.size();
    m_ready = 1'b1;
    start_cmd(32'd3, 16'd5);
    send_beats(30, 1'b1, BASE);
    s_data = 32'hDEAD_BEEF; s_valid = 1'b1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL tog_sready: got %b want 0", s_ready);
    end
    repeat (3) @(posedge clk);
    #1; s_valid = 1'b0;
    wait_done(i0, 300);
    checks++;
    if (wr_cnt - w0 !== 30) begin
      errors++; $display("FAIL tog_wr: got %0d want 30", wr_cnt - w0);
    end
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (d0 + i >= wr_q.size() || wr_q[d0 + i] !== BASE + 32'(i)) begin
        errors++; $display("FAIL tog_data%0d: got %h want %h", i,
                           (d0 + i < wr_q.size()) ? wr_q[d0 + i] : 32'hX, BASE + 32'(i));
      end
    end
    checks++;
    if (rd_cnt - r0 !== 3 || res_name.size() - q0 !== 3 || irq_cnt - i0 !== 1) begin
      errors++; $display("FAIL tog_done: rd=%0d res=%0d irq=%0d want 3 3 1",
                         rd_cnt - r0, res_name.size() - q0, irq_cnt - i0);
    end
  endtask

  task automatic test_stall();
    int r0 = rd_cnt, i0 = irq_cnt, q0 = res_name.size();
    logic [31:0] hn, hv;
    m_ready = 1'b0;
    start_cmd(32'd3, 16'd5);
    send_beats(30, 1'b0, BASE);
    for (int r = 0; r < 3; r++) begin
      int n = 0;
      while (!m_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (!m_valid) begin
        errors++; $display("FAIL stall_valid%0d: m_valid=0 want 1", r);
      end
      if (r == 1) begin
        hn = m_name; hv = m_value;
        checks++;
        if (hn !== 32'h100 + 32'(r0 + 2) || hv !== 32'h5000 + 32'(r0 + 2)) begin
          errors++; $display("FAIL stall_res2: name=%h value=%h want %h %h", hn, hv,
                             32'h100 + 32'(r0 + 2), 32'h5000 + 32'(r0 + 2));
        end
        for (int c = 0; c < 7; c++) begin
          @(negedge clk);
          checks++;
          if (m_valid !== 1'b1 || m_name !== hn || m_value !== hv || rd_cnt - r0 !== 2) begin
            errors++; $display("FAIL stall_hold%0d: valid=%b name=%h value=%h rd=%0d want 1 %h %h 2",
                               c, m_valid, m_name, m_value, rd_cnt - r0, hn, hv);
          end
        end
      end
      @(posedge clk); #1; m_ready = 1'b1;
      @(posedge clk); #1; m_ready = 1'b0;
    end
    m_ready = 1'b1;
    wait_done(i0, 100);
    checks++;
    if (rd_cnt - r0 !== 3 || res_name.size() - q0 !== 3 ||
        (res_name.size() - q0 == 3 && res_last[q0 + 2] !== 1'b1)) begin
      errors++; $display("FAIL stall_done: rd=%0d res=%0d want 3 3 with last", rd_cnt - r0, res_name.size() - q0);
    end
  endtask

  task automatic test_bad_cfg();
    logic [31:0] ks[4] = '{32'd0, 32'd17, 32'd1, 32'd4};
    logic [15:0] ns[4] = '{16'd5, 16'd20, 16'd0, 16'd3};
    int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
    for (int t = 0; t < 4; t++) begin
      start_cmd(ks[t], ns[t]);
      checks++;
      if (err_cfg !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0 || s_ready !== 1'b0) begin
        errors++; $display("FAIL bad_cfg%0d: err=%b busy=%b start=%b sready=%b want 1 0 0 0",
                           t, err_cfg, busy, core_start, s_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (err_cfg !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL bad_pulse%0d: err=%b busy=%b want 0 0", t, err_cfg, busy);
      end
    end
    checks++;
    if (wr_cnt !== w0 || rd_cnt !== r0 || err_cnt - e0 !== 4) begin
      errors++; $display("FAIL bad_activity: wr=%0d rd=%0d errs=%0d want 0 0 4",
                         wr_cnt - w0, rd_cnt - r0, err_cnt - e0);
    end
  endtask

  task automatic test_drain_cmd();
    int r0 = rd_cnt, i0 = irq_cnt, q0 = res_name.size(), e0 = err_cnt;
    m_ready = 1'b1;
    start_cmd(32'd3, 16'd5);
    send_beats(30, 1'b0, BASE);
    start_cmd(32'd2, 16'd2);
    checks++;
    if (err_cfg !== 1'b0 || busy !== 1'b1 || core_k !== 32'd3 || core_done !== 1'b1) begin
      errors++; $display("FAIL drain_cmd: err=%b busy=%b k=%0d done=%b want 0 1 3 1",
                         err_cfg, busy, core_k, core_done);
    end
    wait_done(i0, 300);
    @(posedge clk); #1;
    checks++;
    if (rd_cnt - r0 !== 3 || res_name.size() - q0 !== 3 || err_cnt !== e0 || core_start !== 1'b0) begin
      errors++; $display("FAIL drain_done: rd=%0d res=%0d errs=%0d start=%b want 3 3 0 0",
                         rd_cnt - r0, res_name.size() - q0, err_cnt - e0, core_start);
    end
  endtask

  task automatic test_reset_mid_job();
    int w0, r0, i0, q0;
    m_ready = 1'b1;
    start_cmd(32'd2, 16'd4);
    send_beats(12, 1'b0, BASE);
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== {138{1'b0}}) begin
      errors++; $display("FAIL midrst_outs: got %h want 0", outs());
    end
    @(posedge clk); #1;
    checks++;
    if (outs() !== {138{1'b0}}) begin
      errors++; $display("FAIL midrst_hold: got %h want 0", outs());
    end
    reset = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt; i0 = irq_cnt; q0 = res_name.size();
    start_cmd(32'd3, 16'd5);
    send_beats(30, 1'b0, BASE + 32'h100);
    wait_done(i0, 300);
    checks++;
    if (wr_cnt - w0 !== 30 || rd_cnt - r0 !== 3 || irq_cnt - i0 !== 1 || last_drain !== 10) begin
      errors++; $display("FAIL rerun: wr=%0d rd=%0d irq=%0d drain=%0d want 30 3 1 10",
                         wr_cnt - w0, rd_cnt - r0, irq_cnt - i0, last_drain);
    end
    checks++;
    if (res_name.size() - q0 !== 3 ||
        (res_name.size() - q0 == 3 && (res_name[q0 + 2] !== 32'h100 + 32'(r0 + 3) || res_last[q0 + 2] !== 1'b1))) begin
      errors++; $display("FAIL rerun_res: count=%0d want 3 with last name %h", res_name.size() - q0, 32'h100 + 32'(r0 + 3));
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle();
    test_stall();
    test_bad_cfg();
    test_drain_cmd();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
